// File: rtl/blk_d00d0c.sv
// Output flow-control buffer: a show-ahead beat FIFO toward the encoder plus a
// control-packet holding stage that is released only after every beat written ahead of it.
module blk_d00d0c #(
  parameter int          BITS_PER_SYMBOL    = 8,
  parameter int          SYMBOLS_PER_BEAT   = 3,
  parameter int          DEPTH              = 8,
  parameter int          STALL_MARGIN       = 2,
  parameter logic [15:0] WIDTH_DEFAULT      = 16'd640,
  parameter logic [15:0] HEIGHT_DEFAULT     = 16'd480,
  parameter logic [3:0]  INTERLACED_DEFAULT = 4'd0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  // core side
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  input  logic                                        end_of_video_out,
  input  logic                                        write,
  output logic                                        stall_out,
  input  logic [15:0]                                 width_out,
  input  logic [15:0]                                 height_out,
  input  logic [3:0]                                  interlaced_out,
  input  logic                                        vip_ctrl_valid_out,
  // encoder side
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        encoder_end_of_video,
  output logic [15:0]                                 encoder_width,
  output logic [15:0]                                 encoder_height,
  output logic [3:0]                                  encoder_interlaced,
  output logic                                        encoder_vip_ctrl_send,
  input  logic                                        encoder_vip_ctrl_busy,
  // status
  output logic [$clog2(DEPTH):0]                      fill_level,
  output logic                                        overflow
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);

  typedef struct packed {
    logic          eov;
    logic [DW-1:0] data;
  } beat_t;

  beat_t           mem_q [DEPTH];
  beat_t           head;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d, drain_q, drain_d;
  logic            pend_q, pend_d, send_q, send_d;
  logic            stall_q, stall_d, ovf_q, ovf_d;
  logic [15:0]     width_q, width_d, height_q, height_d;
  logic [3:0]      il_q, il_d;
  logic            empty, full, gate, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);
  // Once every beat ahead of a pending control has left, hold the rest back.
  assign gate  = pend_q & (drain_q == '0);
  assign pop   = dout_valid & dout_ready;
  assign push  = write & (~full | pop);

  assign head                  = mem_q[rd_ptr_q];
  assign dout_valid            = ~empty & ~gate;
  assign dout_data             = head.data;
  assign encoder_end_of_video  = head.eov;
  assign encoder_width         = width_q;
  assign encoder_height        = height_q;
  assign encoder_interlaced    = il_q;
  assign encoder_vip_ctrl_send = send_q;
  assign stall_out             = stall_q;
  assign fill_level            = count_q;
  assign overflow              = ovf_q;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    ovf_d    = ovf_q | (write & ~push) | (vip_ctrl_valid_out & pend_q);
    pend_d   = pend_q;
    drain_d  = drain_q;
    send_d   = 1'b0;
    width_d  = width_q;
    height_d = height_q;
    il_d     = il_q;

    if (!pend_q) begin
      if (vip_ctrl_valid_out) begin
        // A beat pushed this same cycle is counted as ahead of the control.
        pend_d   = 1'b1;
        drain_d  = count_d;
        width_d  = width_out;
        height_d = height_out;
        il_d     = interlaced_out;
      end
    end else if (drain_q == '0) begin
      if (!encoder_vip_ctrl_busy) begin
        send_d = 1'b1;
        pend_d = 1'b0;
      end
    end else if (pop) begin
      drain_d = drain_q - 1'b1;
    end

    stall_d = (count_d >= STALL_LVL) | pend_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= beat_t'{eov: end_of_video_out, data: data_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= '0;
      pend_q   <= 1'b0;
      send_q   <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      width_q  <= WIDTH_DEFAULT;
      height_q <= HEIGHT_DEFAULT;
      il_q     <= INTERLACED_DEFAULT;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
      pend_q   <= pend_d;
      send_q   <= send_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
      width_q  <= width_d;
      height_q <= height_d;
      il_q     <= il_d;
    end
  end

endmodule

// File: tb/tb_blk_d00d0c.sv
// Bench for blk_d00d0c: queue-based reference of the beat stream and control
// release, directed scenarios followed by randomized traffic with mid-run resets.
module tb_blk_d00d0c;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_out = '0;
  logic        end_of_video_out = 1'b0, write = 1'b0, vip_ctrl_valid_out = 1'b0;
  logic [15:0] width_out = '0, height_out = '0;
  logic [3:0]  interlaced_out = '0;
  logic        dout_ready = 1'b0, encoder_vip_ctrl_busy = 1'b0;
  logic        stall_out, dout_valid, encoder_end_of_video, encoder_vip_ctrl_send, overflow;
  logic [23:0] dout_data;
  logic [15:0] encoder_width, encoder_height;
  logic [3:0]  encoder_interlaced;
  logic [3:0]  fill_level;

  blk_d00d0c #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_out(data_out), .end_of_video_out(end_of_video_out), .write(write),
    .stall_out(stall_out), .width_out(width_out), .height_out(height_out),
    .interlaced_out(interlaced_out), .vip_ctrl_valid_out(vip_ctrl_valid_out),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .encoder_end_of_video(encoder_end_of_video), .encoder_width(encoder_width),
    .encoder_height(encoder_height), .encoder_interlaced(encoder_interlaced),
    .encoder_vip_ctrl_send(encoder_vip_ctrl_send),
    .encoder_vip_ctrl_busy(encoder_vip_ctrl_busy),
    .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference state
  logic [24:0] mq[$];
  bit          m_pend, m_send, m_stall, m_ovf;
  int          m_drain;
  logic [15:0] m_w, m_h;
  logic [3:0]  m_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_send = 0; m_stall = 0; m_ovf = 0; m_drain = 0;
    m_w = 16'd640; m_h = 16'd480; m_i = 4'd0;
  endtask

  function automatic bit m_valid();
    return (mq.size() > 0) && !(m_pend && m_drain == 0);
  endfunction

  task automatic check_outputs();
    logic [24:0] hd;
    chk("fill", 32'(fill_level), 32'(mq.size()));
    chk("valid", 32'(dout_valid), 32'(m_valid()));
    if (m_valid()) begin
      hd = mq[0];
      chk("data", 32'(dout_data), 32'(hd[23:0]));
      chk("eov", 32'(encoder_end_of_video), 32'(hd[24]));
    end
    chk("stall", 32'(stall_out), 32'(m_stall));
    chk("send", 32'(encoder_vip_ctrl_send), 32'(m_send));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("width", 32'(encoder_width), 32'(m_w));
    chk("height", 32'(encoder_height), 32'(m_h));
    chk("intl", 32'(encoder_interlaced), 32'(m_i));
  endtask

  // Called at a falling edge: check, drive, advance the reference across one rising edge.
  task automatic cyc(input bit wr, input logic [23:0] d, input bit e, input bit rdy,
                     input bit cv, input logic [15:0] w, input logic [15:0] h,
                     input logic [3:0] il, input bit bsy);
    bit pop, push;
    check_outputs();
    write = wr; data_out = d; end_of_video_out = e; dout_ready = rdy;
    vip_ctrl_valid_out = cv; width_out = w; height_out = h; interlaced_out = il;
    encoder_vip_ctrl_busy = bsy;

    pop  = m_valid() && rdy;
    push = wr && (mq.size() < DEPTH || pop);
    if (wr && !push) m_ovf = 1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({e, d});
    m_send = 0;
    if (m_pend) begin
      if (cv) m_ovf = 1;
      if (m_drain == 0) begin
        if (!bsy) begin m_send = 1; m_pend = 0; end
      end else if (pop) m_drain--;
    end else if (cv) begin
      m_pend = 1; m_drain = mq.size(); m_w = w; m_h = h; m_i = il;
    end
    m_stall = (mq.size() >= DEPTH - MARGIN) || m_pend;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input bit bsy);
    cyc(1'b0, 24'd0, 1'b0, rdy, 1'b0, 16'd0, 16'd0, 4'd0, bsy);
  endtask

  task automatic wbeat(input int v, input bit rdy);
    cyc(1'b1, 24'(v), v[0], rdy, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must go to reset values at once.
  task automatic do_reset();
    write = 1'b0; vip_ctrl_valid_out = 1'b0; dout_ready = 1'b0; encoder_vip_ctrl_busy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_send", 32'(encoder_vip_ctrl_send), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_w", 32'(encoder_width), 32'd640);
    chk("rst_h", 32'(encoder_height), 32'd480);
    chk("rst_i", 32'(encoder_interlaced), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // fill with no reader: stall timing, full, dropped write
    for (int i = 0; i < 9; i++) begin
      wbeat(16 + i, 1'b0);
      if (i == 4) chk("fill_stall5", 32'(stall_out), 32'd0);
      if (i == 5) chk("fill_stall6", 32'(stall_out), 32'd1);
    end
    chk("fill_lvl8", 32'(fill_level), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd1);

    // full FIFO with simultaneous write and read
    do_reset();
    for (int i = 0; i < 8; i++) wbeat(100 + i, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wbeat(200 + i, 1'b1);
      chk("full_rw_lvl", 32'(fill_level), 32'd8);
    end
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b1, 1'b0);

    // control behind three beats
    do_reset();
    for (int i = 0; i < 3; i++) wbeat(768 + i, 1'b0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 16'd1920, 16'd1080, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0);
      chk("ctrl_hold_send", 32'(encoder_vip_ctrl_send), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("ctrl_beat_valid", 32'(dout_valid), 32'd1);
      idle(1'b1, 1'b0);
    end
    chk("ctrl_send_pre", 32'(encoder_vip_ctrl_send), 32'd0);
    idle(1'b1, 1'b0);
    chk("ctrl_send", 32'(encoder_vip_ctrl_send), 32'd1);
    idle(1'b1, 1'b0);
    chk("ctrl_send_once", 32'(encoder_vip_ctrl_send), 32'd0);
    chk("ctrl_w", 32'(encoder_width), 32'd1920);
    chk("ctrl_h", 32'(encoder_height), 32'd1080);

    // control on empty FIFO with encoder busy
    do_reset();
    cyc(1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 16'd800, 16'd600, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 24'(4096 + i), 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
      chk("busy_gate", 32'(dout_valid), 32'd0);
    end
    idle(1'b1, 1'b0);
    chk("busy_send", 32'(encoder_vip_ctrl_send), 32'd1);
    for (int i = 0; i < 7; i++) idle(1'b1, 1'b0);

    // second control while pending
    do_reset();
    wbeat(7, 1'b0); wbeat(8, 1'b0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 16'd1280, 16'd720, 4'd2, 1'b0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 16'd111, 16'd222, 4'd3, 1'b0);
    chk("dup_ovf", 32'(overflow), 32'd1);
    chk("dup_w", 32'(encoder_width), 32'd1280);
    chk("dup_h", 32'(encoder_height), 32'd720);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);

    // reset with buffered beats and a pending control
    do_reset();
    for (int i = 0; i < 5; i++) wbeat(50 + i, 1'b0);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 16'd1024, 16'd768, 4'd1, 1'b0);
    do_reset();
    idle(1'b1, 1'b0);
    chk("post_rst_fill", 32'(fill_level), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      cyc($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
          16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
